// File: rtl/sram4_arbiter.sv
// rtl/sram4_arbiter.sv - two-requester round-robin arbiter and access sequencer for SRAM4
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_din   requester A transaction (req held until a_done)
//   a_done, a_rdata      A completion pulse and read data (held until next A read)
//   b_*                  same set for requester B
//   mem_addr, mem_din, mem_rw  registered SRAM4 drive (mem_rw = write strobe)
//   mem_dout             SRAM4 combinational read data
//   busy                 high whenever the sequencer is not idle

module sram4_arbiter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [1:0] a_addr,
    input  logic [3:0] a_din,
    output logic       a_done,
    output logic [3:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [1:0] b_addr,
    input  logic [3:0] b_din,
    output logic       b_done,
    output logic [3:0] b_rdata,
    output logic [1:0] mem_addr,
    output logic [3:0] mem_din,
    output logic       mem_rw,
    input  logic [3:0] mem_dout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   last_b;
    logic   gnt_b;
    logic   cur_we;
    logic   grant_b;

    // B wins only if A is idle, or on a tie when A was the one served last.
    assign grant_b = b_req & (~a_req | ~last_b);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            gnt_b    <= 1'b0;
            cur_we   <= 1'b0;
            mem_addr <= 2'd0;
            mem_din  <= 4'd0;
            mem_rw   <= 1'b0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            a_rdata  <= 4'd0;
            b_rdata  <= 4'd0;
            busy     <= 1'b0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        state    <= ACCESS;
                        busy     <= 1'b1;
                        last_b   <= grant_b;
                        gnt_b    <= grant_b;
                        // Everything the transaction needs is latched here, so the
                        // requester may change or drop its inputs from now on.
                        cur_we   <= grant_b ? b_we   : a_we;
                        mem_rw   <= grant_b ? b_we   : a_we;
                        mem_addr <= grant_b ? b_addr : a_addr;
                        mem_din  <= grant_b ? b_din  : a_din;
                    end
                end
                ACCESS: begin
                    state  <= RESP;
                    // Write strobe lasts exactly the ACCESS cycle.
                    mem_rw <= 1'b0;
                    if (gnt_b) begin
                        b_done <= 1'b1;
                    end else begin
                        a_done <= 1'b1;
                    end
                    if (!cur_we) begin
                        if (gnt_b) begin
                            b_rdata <= mem_dout;
                        end else begin
                            a_rdata <= mem_dout;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_rw <= 1'b0;
                end
            endcase
        end
    end

endmodule
